// File: rtl/snake_pkg.sv
// Shared direction encoding, switch bit positions and helpers for the snake input front end.
// Pure definitions: no state, no latency, no flow control.
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   localparam dir_t DIR_RESET = DIR_RIGHT;

   localparam int SW_UP    = 3;
   localparam int SW_DOWN  = 2;
   localparam int SW_LEFT  = 1;
   localparam int SW_RIGHT = 0;

   // Up/down and left/right pairs differ only in bit 0.
   function automatic dir_t opposite(input dir_t d);
      return d ^ 2'b01;
   endfunction

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic dir_t sw_to_dir(input logic [3:0] v);
      dir_t d;
      d = DIR_RIGHT;
      if (v[SW_UP])
         d = DIR_UP;
      else if (v[SW_DOWN])
         d = DIR_DOWN;
      else if (v[SW_LEFT])
         d = DIR_LEFT;
      return d;
   endfunction

endpackage

// File: rtl/snake_debounce.sv
// Two-flop synchroniser plus whole-vector debounce; raw-to-stable latency is 2 + DEBOUNCE_CYCLES.
// No backpressure: the stable vector simply follows the keys once they settle.
module snake_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 24
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] switch,
   output logic [3:0] stable
);

   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       candidate;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1     <= 4'b0000;
         sync2     <= 4'b0000;
         candidate <= 4'b0000;
         cnt       <= '0;
         stable    <= 4'b0000;
      end else begin
         sync1 <= switch;
         sync2 <= sync1;
         // Any change in the vector restarts the settle window; the counter parks once it expires.
         if (sync2 != candidate) begin
            candidate <= sync2;
            cnt       <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= candidate;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/snake_input_ctrl.sv
// Direction keys to committed heading plus game-step tick; turns commit only on tick, reversals rejected.
// No backpressure: tick/turn/reject are single-cycle strobes, press event lags stable by one cycle.
module snake_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_DIV        = 5000000,
   parameter int CNT_W           = 24
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic [3:0] switch,
   output logic [1:0] direction,
   output logic       tick,
   output logic       turn,
   output logic       reject
);
   import snake_pkg::*;

   logic [3:0]       stable;
   logic [3:0]       prev_stable;
   logic             press_vld;
   dir_t             press_dir;
   logic [CNT_W-1:0] tick_cnt;
   logic             tick_q;
   dir_t             dir_q;
   dir_t             pending;
   logic             pending_valid;
   dir_t             ref_dir;
   logic             press_bad;

   snake_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_debounce (
      .clock (clock),
      .reset (reset),
      .switch(switch),
      .stable(stable)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_stable <= 4'b0000;
         press_vld   <= 1'b0;
         press_dir   <= DIR_UP;
      end else begin
         prev_stable <= stable;
         press_vld   <= (stable != prev_stable) && is_onehot(stable);
         press_dir   <= sw_to_dir(stable);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         tick_q   <= 1'b0;
      end else if (!run) begin
         tick_cnt <= '0;
         tick_q   <= 1'b0;
      end else if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
         tick_cnt <= '0;
         tick_q   <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
         tick_q   <= 1'b0;
      end
   end

   // During a tick the heading being committed is the one a coincident press must not reverse.
   always_comb begin
      ref_dir = dir_q;
      if (tick_q && pending_valid)
         ref_dir = pending;
      press_bad = (press_dir == ref_dir) || (press_dir == opposite(ref_dir));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dir_q         <= DIR_RESET;
         pending       <= DIR_UP;
         pending_valid <= 1'b0;
      end else begin
         if (tick_q && pending_valid)
            dir_q <= pending;
         if (press_vld && !press_bad)
            pending <= press_dir;
         if (!run)
            pending_valid <= 1'b0;
         else if (press_vld && !press_bad)
            pending_valid <= 1'b1;
         else if (tick_q)
            pending_valid <= 1'b0;
      end
   end

   assign direction = dir_q;
   assign tick      = tick_q;
   assign turn      = tick_q && pending_valid && (pending != dir_q);
   assign reject    = press_vld && press_bad;

endmodule

// File: tb/tb_snake_input_ctrl.sv
module tb_snake_input_ctrl;
   import snake_pkg::*;

   localparam int DEB  = 4;
   localparam int TDIV = 10;

   logic       clock = 1'b0;
   logic       reset;
   logic       run;
   logic [3:0] switch;
   logic [1:0] direction;
   logic       tick;
   logic       turn;
   logic       reject;

   snake_input_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .TICK_DIV       (TDIV),
      .CNT_W          (24)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .switch   (switch),
      .direction(direction),
      .tick     (tick),
      .turn     (turn),
      .reject   (reject)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       is_turn;
      logic [1:0] dir;
   } ev_t;

   typedef struct packed {
      logic [3:0] sw;
      logic       exp_rej;
      logic       exp_turn;
      logic [1:0] exp_dir;
   } vec_t;

   ev_t  exp_q[$];
   vec_t tbl[10];

   int   n_checks  = 0;
   int   n_fail    = 0;
   int   tick_seen = 0;
   int   rej_seen  = 0;
   logic sb_on     = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Returns the number of falling edges until tick is seen (40 if it never comes).
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!tick && n < 40);
   endtask

   // Scoreboard: every reject and every turn must match the next predicted event.
   initial begin
      ev_t        e;
      logic       pend_chk;
      logic [1:0] pend_dir;
      pend_chk = 1'b0;
      pend_dir = 2'd0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            pend_chk = 1'b0;
         end else if (sb_on) begin
            if (pend_chk) begin
               check("sb_dir_after_turn", direction, pend_dir);
               pend_chk = 1'b0;
            end
            if (tick)
               tick_seen++;
            if (reject) begin
               rej_seen++;
               check("sb_reject_was_predicted", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("sb_reject_kind", e.is_turn, 0);
                  check("sb_reject_dir", direction, e.dir);
               end
            end
            if (turn) begin
               check("sb_turn_with_tick", tick, 1);
               check("sb_turn_was_predicted", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("sb_turn_kind", e.is_turn, 1);
                  pend_chk = 1'b1;
                  pend_dir = e.dir;
               end
            end
         end
      end
   end

   initial begin
      int n;
      int rej_at;
      int r0;
      int t0;

      // Applied in order, each starting right after a tick; heading begins at right.
      tbl[0] = '{4'b1000, 1'b0, 1'b1, DIR_UP};
      tbl[1] = '{4'b0100, 1'b1, 1'b0, DIR_UP};
      tbl[2] = '{4'b1000, 1'b1, 1'b0, DIR_UP};
      tbl[3] = '{4'b0010, 1'b0, 1'b1, DIR_LEFT};
      tbl[4] = '{4'b0001, 1'b1, 1'b0, DIR_LEFT};
      tbl[5] = '{4'b0100, 1'b0, 1'b1, DIR_DOWN};
      tbl[6] = '{4'b1100, 1'b0, 1'b0, DIR_DOWN};
      tbl[7] = '{4'b0000, 1'b0, 1'b0, DIR_DOWN};
      tbl[8] = '{4'b0001, 1'b0, 1'b1, DIR_RIGHT};
      tbl[9] = '{4'b0010, 1'b1, 1'b0, DIR_RIGHT};

      reset  = 1'b0;
      run    = 1'b0;
      switch = 4'b0000;
      repeat (3) @(negedge clock);
      check("reset_direction", direction, 3);
      check("reset_tick", tick, 0);
      check("reset_turn", turn, 0);
      check("reset_reject", reject, 0);

      reset = 1'b1;
      sb_on = 1'b1;
      repeat (2) @(negedge clock);
      run = 1'b1;
      wait_tick(n);
      check("first_tick_latency", n, TDIV);
      @(negedge clock);
      check("tick_width", tick, 0);
      wait_tick(n);
      check("tick_period", n + 1, TDIV);

      // Press is sampled on the next rising edge; its reject shows 8 falling edges after the drive.
      for (int i = 0; i < 10; i++) begin
         switch = tbl[i].sw;
         if (tbl[i].exp_rej)
            exp_q.push_back('{1'b0, tbl[i].exp_dir});
         if (tbl[i].exp_turn)
            exp_q.push_back('{1'b1, tbl[i].exp_dir});
         rej_at = -1;
         for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (reject && rej_at < 0)
               rej_at = k;
         end
         check($sformatf("vec%0d_reject_cycle", i), rej_at, tbl[i].exp_rej ? 8 : -1);
         check($sformatf("vec%0d_tick_phase", i), tick, 1);
         switch = 4'b0000;
         @(negedge clock);
         check($sformatf("vec%0d_direction", i), direction, tbl[i].exp_dir);
         wait_tick(n);
      end

      // Bounce shorter than the debounce window.
      r0 = rej_seen;
      for (int i = 0; i < 6; i++) begin
         switch = (i % 2 == 0) ? 4'b1000 : 4'b0000;
         repeat (2) @(negedge clock);
      end
      switch = 4'b0000;
      repeat (12) @(negedge clock);
      check("bounce_no_reject", rej_seen - r0, 0);
      check("bounce_direction", direction, 3);
      wait_tick(n);

      // Pending up, then run low discards it.
      switch = 4'b1000;
      repeat (9) @(negedge clock);
      run = 1'b0;
      t0  = tick_seen;
      repeat (20) @(negedge clock);
      check("run_low_no_tick", tick_seen - t0, 0);
      run = 1'b1;
      wait_tick(n);
      check("run_rise_tick_latency", n, TDIV);
      check("run_rise_no_turn", turn, 0);
      @(negedge clock);
      check("run_low_discard_dir", direction, 3);
      switch = 4'b0000;
      repeat (10) @(negedge clock);
      wait_tick(n);

      // Up then down inside one tick period: the later press wins.
      repeat (5) @(negedge clock);
      switch = 4'b1000;
      exp_q.push_back('{1'b1, DIR_DOWN});
      repeat (5) @(negedge clock);
      switch = 4'b0100;
      repeat (10) @(negedge clock);
      check("last_wins_tick", tick, 1);
      check("last_wins_turn", turn, 1);
      @(negedge clock);
      check("last_wins_dir", direction, 1);
      r0 = rej_seen;
      switch = 4'b1100;
      repeat (12) @(negedge clock);
      switch = 4'b0000;
      repeat (12) @(negedge clock);
      check("multihot_no_reject", rej_seen - r0, 0);
      check("multihot_dir", direction, 1);

      // Asynchronous reset in the middle of a cycle.
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("async_reset_dir", direction, 3);
      check("async_reset_tick", tick, 0);
      check("async_reset_turn", turn, 0);
      check("async_reset_reject", reject, 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      wait_tick(n);
      check("post_reset_first_tick", n, TDIV);
      check("post_reset_direction", direction, 3);

      check("sb_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
